// File: rtl/boot_loader8_if.sv
// Byte-stream boot loader bus: UART byte strobe in, memory boot-write port
// and host status out.
interface boot_loader8_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        debug;
  logic [12:0] boot_addr;
  logic [7:0]  boot_data;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  rx_valid, rx_data,
    output debug, boot_addr, boot_data,
    output busy, done, err
  );

  modport slave (
    output rx_valid, rx_data,
    input  debug, boot_addr, boot_data,
    input  busy, done, err
  );
endinterface

// File: rtl/boot_loader8.sv
// Framed byte loader: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, data, CSUM.
// Drives the 8 KB memory boot-write port while holding the CPU off.
module boot_loader8 #(
  parameter int unsigned TIMEOUT = 1048576,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader8_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, AH, AL, LH, LL, DATA, CK
  } state_t;

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic [12:0]   start;
  logic [7:0]    len_h;
  logic [15:0]   remain;
  logic [7:0]    sum;
  logic          first;
  logic [7:0]    rx;

  assign rx = bus.rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idle_cnt      <= '0;
      start         <= '0;
      len_h         <= '0;
      remain        <= '0;
      sum           <= '0;
      first         <= 1'b0;
      bus.debug     <= 1'b0;
      bus.boot_addr <= '0;
      bus.boot_data <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.rx_valid) begin
        // an accepted byte always beats a timeout on the same edge
        idle_cnt <= '0;
        unique case (state)
          IDLE: begin
            if (rx == SYNC) begin
              state    <= AH;
              sum      <= '0;
              bus.err  <= 1'b0;
              bus.busy <= 1'b1;
            end
          end
          AH: begin
            start[12:8] <= rx[4:0];
            sum         <= sum + rx;
            state       <= AL;
          end
          AL: begin
            start[7:0] <= rx;
            sum        <= sum + rx;
            state      <= LH;
          end
          LH: begin
            len_h <= rx;
            sum   <= sum + rx;
            state <= LL;
          end
          LL: begin
            sum    <= sum + rx;
            remain <= {len_h, rx};
            first  <= 1'b1;
            state  <= ({len_h, rx} == 16'd0) ? CK : DATA;
          end
          DATA: begin
            bus.boot_data <= rx;
            bus.boot_addr <= first ? start
                                   : bus.boot_addr + 13'd1;
            bus.debug     <= 1'b1;
            first         <= 1'b0;
            sum           <= sum + rx;
            remain        <= remain - 16'd1;
            if (remain == 16'd1) state <= CK;
          end
          CK: begin
            bus.debug <= 1'b0;
            bus.done  <= 1'b1;
            bus.err   <= (rx != sum);
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        if (idle_cnt == CW'(TIMEOUT - 1)) begin
          state     <= IDLE;
          idle_cnt  <= '0;
          bus.debug <= 1'b0;
          bus.busy  <= 1'b0;
          bus.err   <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule
